segre_exception_unit: RTL and testbench

//  Trap controller upstream of the CSR register file. Collects synchronous exception requests

---
 rtl/segre_exception_unit.sv | 188 ++++++++++++++++++
 tb/tb_segre_exception_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/segre_exception_unit.sv
// ----------------------------------------------------------------------------
// segre_exception_unit
// Trap controller in front of the CSR register file. It arbitrates synchronous
// exceptions from IF/ID/MEM and MRET commits from MEM, then writes the machine
// trap CSRs. After that it flushes the pipeline and redirects fetch. Only one
// event is in flight at a time.
//
// Ports
//   clk_i, rsn_i              clock, asynchronous active-low reset
//   if_/id_/mem_exc_i         per-stage exception request
//   if_/id_/mem_cause_i       per-stage cause code
//   if_/id_/mem_pc_i          per-stage instruction PC
//   mret_i                    MRET commits in MEM this cycle
//   mstatus_i..mcause_i       current CSR values
//   exc_we_o, w_data_m*_o     CSR exception write port
//   flush_o                   kill IF..MEM
//   redirect_o/redirect_pc_o  fetch redirect
//   busy_o                    event in flight
// ----------------------------------------------------------------------------
module segre_exception_unit #(
    parameter int unsigned WORD_SIZE   = 32,
    parameter int unsigned CAUSE_WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rsn_i,
    input  logic                   if_exc_i,
    input  logic [CAUSE_WIDTH-1:0] if_cause_i,
    input  logic [WORD_SIZE-1:0]   if_pc_i,
    input  logic                   id_exc_i,
    input  logic [CAUSE_WIDTH-1:0] id_cause_i,
    input  logic [WORD_SIZE-1:0]   id_pc_i,
    input  logic                   mem_exc_i,
    input  logic [CAUSE_WIDTH-1:0] mem_cause_i,
    input  logic [WORD_SIZE-1:0]   mem_pc_i,
    input  logic                   mret_i,
    input  logic [WORD_SIZE-1:0]   mstatus_i,
    input  logic [WORD_SIZE-1:0]   mtvec_i,
    input  logic [WORD_SIZE-1:0]   mepc_i,
    input  logic [WORD_SIZE-1:0]   mcause_i,
    output logic                   exc_we_o,
    output logic [WORD_SIZE-1:0]   w_data_mstatus_o,
    output logic [WORD_SIZE-1:0]   w_data_mtvec_o,
    output logic [WORD_SIZE-1:0]   w_data_mepc_o,
    output logic [WORD_SIZE-1:0]   w_data_mcause_o,
    output logic                   flush_o,
    output logic                   redirect_o,
    output logic [WORD_SIZE-1:0]   redirect_pc_o,
    output logic                   busy_o
);

    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;
    localparam int unsigned MPP_LO   = 11;
    localparam int unsigned MPP_HI   = 12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP     = 2'd1,
        MRET     = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    state_e r_state;
    state_e w_next;

    logic [CAUSE_WIDTH-1:0] w_sel_cause;
    logic [WORD_SIZE-1:0]   w_sel_pc;
    logic [WORD_SIZE-1:0]   w_trap_mstatus;
    logic [WORD_SIZE-1:0]   w_mret_mstatus;

    logic                   r_exc_we;
    logic                   r_flush;
    logic                   r_redirect;
    logic                   r_busy;
    logic [WORD_SIZE-1:0]   r_mstatus;
    logic [WORD_SIZE-1:0]   r_mtvec;
    logic [WORD_SIZE-1:0]   r_mepc;
    logic [WORD_SIZE-1:0]   r_mcause;
    logic [WORD_SIZE-1:0]   r_target;
    logic [WORD_SIZE-1:0]   r_redirect_pc;

    // Oldest excepting stage wins; MRET is arbitrated in the next-state logic.
    always_comb begin
        w_sel_cause = if_cause_i;
        w_sel_pc    = if_pc_i;
        if (mem_exc_i) begin
            w_sel_cause = mem_cause_i;
            w_sel_pc    = mem_pc_i;
        end else if (id_exc_i) begin
            w_sel_cause = id_cause_i;
            w_sel_pc    = id_pc_i;
        end
    end

    // mstatus update for trap entry and for return.
    always_comb begin
        w_trap_mstatus                = mstatus_i;
        w_trap_mstatus[MPIE_BIT]      = mstatus_i[MIE_BIT];
        w_trap_mstatus[MIE_BIT]       = 1'b0;
        w_trap_mstatus[MPP_HI:MPP_LO] = 2'b11;

        w_mret_mstatus                = mstatus_i;
        w_mret_mstatus[MIE_BIT]       = mstatus_i[MPIE_BIT];
        w_mret_mstatus[MPIE_BIT]      = 1'b1;
        w_mret_mstatus[MPP_HI:MPP_LO] = 2'b11;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state; inputs only matter in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (mem_exc_i) begin
                    w_next = TRAP;
                end else if (mret_i) begin
                    w_next = MRET;
                end else if (id_exc_i || if_exc_i) begin
                    w_next = TRAP;
                end
            end
            TRAP:     w_next = REDIRECT;
            MRET:     w_next = REDIRECT;
            REDIRECT: w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Registered outputs: strobes follow the state being entered, data is
    // captured on the IDLE edge and held until the next event.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_exc_we      <= 1'b0;
            r_flush       <= 1'b0;
            r_redirect    <= 1'b0;
            r_busy        <= 1'b0;
            r_mstatus     <= '0;
            r_mtvec       <= '0;
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_target      <= '0;
            r_redirect_pc <= '0;
        end else begin
            r_exc_we   <= (w_next == TRAP) || (w_next == MRET);
            r_flush    <= (w_next != IDLE);
            r_redirect <= (w_next == REDIRECT);
            r_busy     <= (w_next != IDLE);

            if (r_state == IDLE && w_next == TRAP) begin
                r_mstatus <= w_trap_mstatus;
                r_mtvec   <= mtvec_i;
                r_mepc    <= {w_sel_pc[WORD_SIZE-1:2], 2'b00};
                r_mcause  <= WORD_SIZE'(w_sel_cause);
                // Vectored mode does not apply to exceptions: always base.
                r_target  <= {mtvec_i[WORD_SIZE-1:2], 2'b00};
            end else if (r_state == IDLE && w_next == MRET) begin
                r_mstatus <= w_mret_mstatus;
                r_mtvec   <= mtvec_i;
                r_mepc    <= mepc_i;
                r_mcause  <= mcause_i;
                r_target  <= mepc_i;
            end

            if (w_next == REDIRECT) begin
                r_redirect_pc <= r_target;
            end
        end
    end

    assign exc_we_o         = r_exc_we;
    assign flush_o          = r_flush;
    assign redirect_o       = r_redirect;
    assign busy_o           = r_busy;
    assign w_data_mstatus_o = r_mstatus;
    assign w_data_mtvec_o   = r_mtvec;
    assign w_data_mepc_o    = r_mepc;
    assign w_data_mcause_o  = r_mcause;
    assign redirect_pc_o    = r_redirect_pc;

endmodule

// File: tb/tb_segre_exception_unit.sv
// ----------------------------------------------------------------------------
// tb_segre_exception_unit
// Directed and randomized events against a behavioural model of the trap
// controller (priority rules and CSR bit arithmetic on plain integers).
// ----------------------------------------------------------------------------
module tb_segre_exception_unit;

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic        if_exc_i, id_exc_i, mem_exc_i, mret_i;
    logic [3:0]  if_cause_i, id_cause_i, mem_cause_i;
    logic [31:0] if_pc_i, id_pc_i, mem_pc_i;
    logic [31:0] mstatus_i, mtvec_i, mepc_i, mcause_i;
    logic        exc_we_o, flush_o, redirect_o, busy_o;
    logic [31:0] w_data_mstatus_o, w_data_mtvec_o, w_data_mepc_o, w_data_mcause_o;
    logic [31:0] redirect_pc_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Last CSR write data the model expects the DUT to be holding.
    logic [31:0] h_mstatus = '0, h_mtvec = '0, h_mepc = '0, h_mcause = '0;

    always #5 clk_i = ~clk_i;

    segre_exception_unit #(.WORD_SIZE(32), .CAUSE_WIDTH(4)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .if_exc_i(if_exc_i), .if_cause_i(if_cause_i), .if_pc_i(if_pc_i),
        .id_exc_i(id_exc_i), .id_cause_i(id_cause_i), .id_pc_i(id_pc_i),
        .mem_exc_i(mem_exc_i), .mem_cause_i(mem_cause_i), .mem_pc_i(mem_pc_i),
        .mret_i(mret_i),
        .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mcause_i(mcause_i),
        .exc_we_o(exc_we_o),
        .w_data_mstatus_o(w_data_mstatus_o), .w_data_mtvec_o(w_data_mtvec_o),
        .w_data_mepc_o(w_data_mepc_o), .w_data_mcause_o(w_data_mcause_o),
        .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .busy_o(busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_req();
        if_exc_i = 0; id_exc_i = 0; mem_exc_i = 0; mret_i = 0;
        if_cause_i = 0; id_cause_i = 0; mem_cause_i = 0;
        if_pc_i = 0; id_pc_i = 0; mem_pc_i = 0;
    endtask

    task automatic garbage_req();
        if_exc_i   = 1'($urandom);  id_exc_i   = 1'($urandom);
        mem_exc_i  = 1'($urandom);  mret_i     = 1'($urandom);
        if_cause_i = 4'($urandom);  id_cause_i = 4'($urandom);
        mem_cause_i = 4'($urandom);
        if_pc_i = $urandom; id_pc_i = $urandom; mem_pc_i = $urandom;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_we"},     32'(exc_we_o),   0);
        check_eq({tag, "_flush"},  32'(flush_o),    0);
        check_eq({tag, "_redir"},  32'(redirect_o), 0);
        check_eq({tag, "_busy"},   32'(busy_o),     0);
        check_eq({tag, "_mstat"},  w_data_mstatus_o, h_mstatus);
        check_eq({tag, "_mepc"},   w_data_mepc_o,    h_mepc);
        check_eq({tag, "_mcause"}, w_data_mcause_o,  h_mcause);
        check_eq({tag, "_mtvec"},  w_data_mtvec_o,   h_mtvec);
    endtask

    // Called #1 after an edge with request inputs set; runs one full event
    // and returns #1 after the edge where the block is idle again.
    task automatic do_event(input string tag);
        int          kind;      // 0 none, 1 trap, 2 mret
        logic [31:0] cause, pc, target;
        logic [31:0] e_ms, e_tv, e_ep, e_mc;
        logic [31:0] ms;
        kind = 0; cause = 0; pc = 0;
        if (mem_exc_i)     begin kind = 1; cause = 32'(mem_cause_i); pc = mem_pc_i; end
        else if (mret_i)   kind = 2;
        else if (id_exc_i) begin kind = 1; cause = 32'(id_cause_i); pc = id_pc_i; end
        else if (if_exc_i) begin kind = 1; cause = 32'(if_cause_i); pc = if_pc_i; end

        ms = mstatus_i;
        if (kind == 1) begin
            e_ms   = (ms & ~32'h1888) | (((ms >> 3) & 1) << 7) | 32'h1800;
            e_tv   = mtvec_i;
            e_ep   = pc & ~32'h3;
            e_mc   = cause;
            target = mtvec_i & ~32'h3;
        end else begin
            e_ms   = (ms & ~32'h1888) | (((ms >> 7) & 1) << 3) | 32'h0080 | 32'h1800;
            e_tv   = mtvec_i;
            e_ep   = mepc_i;
            e_mc   = mcause_i;
            target = mepc_i;
        end

        @(posedge clk_i); #1;
        if (kind == 0) begin
            check_quiet({tag, "_none"});
            return;
        end
        garbage_req();
        check_eq({tag, "_c1_we"},     32'(exc_we_o),   1);
        check_eq({tag, "_c1_flush"},  32'(flush_o),    1);
        check_eq({tag, "_c1_busy"},   32'(busy_o),     1);
        check_eq({tag, "_c1_redir"},  32'(redirect_o), 0);
        check_eq({tag, "_mstatus"},   w_data_mstatus_o, e_ms);
        check_eq({tag, "_mtvec"},     w_data_mtvec_o,   e_tv);
        check_eq({tag, "_mepc"},      w_data_mepc_o,    e_ep);
        check_eq({tag, "_mcause"},    w_data_mcause_o,  e_mc);
        h_mstatus = e_ms; h_mtvec = e_tv; h_mepc = e_ep; h_mcause = e_mc;

        @(posedge clk_i); #1;
        garbage_req();
        check_eq({tag, "_c2_redir"},  32'(redirect_o), 1);
        check_eq({tag, "_c2_pc"},     redirect_pc_o,   target);
        check_eq({tag, "_c2_we"},     32'(exc_we_o),   0);
        check_eq({tag, "_c2_flush"},  32'(flush_o),    1);
        check_eq({tag, "_c2_busy"},   32'(busy_o),     1);
        check_eq({tag, "_c2_mepc"},   w_data_mepc_o,   h_mepc);

        @(posedge clk_i); #1;
        clear_req();
        check_quiet({tag, "_c3"});
    endtask

    initial begin
        rsn_i = 0;
        clear_req();
        mstatus_i = 0; mtvec_i = 0; mepc_i = 0; mcause_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check_quiet("reset");
        check_eq("reset_rpc", redirect_pc_o, 0);
        rsn_i = 1;
        @(posedge clk_i); #1;
        check_quiet("post_reset");

        // ID illegal instruction
        id_exc_i = 1; id_cause_i = 2; id_pc_i = 32'h100;
        mtvec_i = 32'h800; mstatus_i = 32'h8;
        do_event("id_illegal");
        check_eq("id_illegal_ms_const", h_mstatus, 32'h1880);

        // MEM beats ID and IF
        mem_exc_i = 1; mem_cause_i = 5; mem_pc_i = 32'h200;
        id_exc_i = 1; id_cause_i = 2; id_pc_i = 32'h104;
        if_exc_i = 1; if_cause_i = 1; if_pc_i = 32'h108;
        do_event("mem_prio");
        check_eq("mem_prio_cause_const", h_mcause, 5);

        // MRET
        mret_i = 1; mepc_i = 32'h104; mstatus_i = 32'h1880; mcause_i = 32'h5;
        do_event("mret");
        check_eq("mret_ms_const", h_mstatus, 32'h1888);

        // MRET beats ID exception
        mret_i = 1; id_exc_i = 1; id_cause_i = 11; id_pc_i = 32'h300;
        mepc_i = 32'h204; mstatus_i = 32'h80;
        do_event("mret_vs_id");

        // Vectored mtvec and misaligned PC
        if_exc_i = 1; if_cause_i = 0; if_pc_i = 32'h203;
        mtvec_i = 32'h801; mstatus_i = 32'h0;
        do_event("vec_mtvec");

        // Reset in TRAP abandons the event
        id_exc_i = 1; id_cause_i = 3; id_pc_i = 32'h400;
        @(posedge clk_i); #1;
        clear_req();
        check_eq("rst_pre_we", 32'(exc_we_o), 1);
        rsn_i = 0;
        #1;
        h_mstatus = 0; h_mtvec = 0; h_mepc = 0; h_mcause = 0;
        check_quiet("rst_mid");
        check_eq("rst_mid_rpc", redirect_pc_o, 0);
        #2 rsn_i = 1;
        repeat (2) begin
            @(posedge clk_i); #1;
            check_quiet("rst_after");
        end

        // Randomized events, including idle cycles
        for (int i = 0; i < 300; i++) begin
            mstatus_i = $urandom; mtvec_i = $urandom;
            mepc_i = $urandom; mcause_i = $urandom;
            mem_exc_i  = ($urandom_range(0, 3) == 0);
            mret_i     = ($urandom_range(0, 3) == 0);
            id_exc_i   = ($urandom_range(0, 2) == 0);
            if_exc_i   = ($urandom_range(0, 2) == 0);
            mem_cause_i = 4'($urandom_range(4, 7));
            id_cause_i  = 4'($urandom_range(0, 15));
            if_cause_i  = 4'($urandom_range(0, 1));
            mem_pc_i = $urandom; id_pc_i = $urandom; if_pc_i = $urandom;
            do_event("rnd");
            clear_req();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
